seq_player: RTL and testbench

SEQ_PLAYER -- requirements
Module: seq_player

---
 rtl/seq_player_pkg.sv | 28 ++
 rtl/seq_addr_counter.sv | 68 ++++++
 rtl/seq_player.sv | 145 ++++++++++++++
 tb/tb_seq_player.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_player_pkg.sv
// Shared types and descriptor layout for the sequence player.
// Descriptor layout: {start[2*ADDR_W:ADDR_W+1], end[ADDR_W:1], last[0]}.
package seq_player_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  localparam int unsigned ADDR_W_DEF    = 10;
  localparam int unsigned IDX_W_DEF     = 7;
  localparam int unsigned DESC_LAST_BIT = 0;
  localparam int unsigned DESC_END_LSB  = 1;

  // Total descriptor width for a given playback address width.
  function automatic int unsigned desc_w(input int unsigned aw);
    return 2 * aw + 1;
  endfunction

  // Bit offset of the start field inside a descriptor.
  function automatic int unsigned desc_start_lsb(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/seq_addr_counter.sv
// Playback address counter: loads start/end, steps or wraps, flags end.
// Ports:
//   clk_i, rst_i     clock, async active-high reset
//   load_i           capture start_i/end_i, addr := start_i
//   start_i, end_i   descriptor bounds
//   step_i           advance one address (wraps to start once at end)
//   valid_d_i        next cycle is a playback cycle (qualifies at_end_o)
//   addr_o           current playback address
//   at_end_o         registered: valid playback cycle with addr at end
//   end_hit_c_o      combinational: addr has reached (or passed) end
module seq_addr_counter
  import seq_player_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] start_i,
  input  logic [ADDR_W-1:0] end_i,
  input  logic              step_i,
  input  logic              valid_d_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              at_end_o,
  output logic              end_hit_c_o
);

  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              at_end_q;

  // start > end counts as already at the end, so a reversed range plays one address.
  assign end_hit_c_o = (addr_q >= end_q);

  // Next address / bounds.
  always_comb begin
    start_d = start_q;
    end_d   = end_q;
    addr_d  = addr_q;
    if (load_i) begin
      start_d = start_i;
      end_d   = end_i;
      addr_d  = start_i;
    end else if (step_i) begin
      addr_d = end_hit_c_o ? start_q : addr_q + ADDR_W'(1);
    end
  end

  // Counter registers; at_end is computed from the next values so it lines up with addr.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      start_q  <= '0;
      end_q    <= '0;
      addr_q   <= '0;
      at_end_q <= 1'b0;
    end else begin
      start_q  <= start_d;
      end_q    <= end_d;
      addr_q   <= addr_d;
      at_end_q <= valid_d_i && (addr_d >= end_d);
    end
  end

  assign addr_o   = addr_q;
  assign at_end_o = at_end_q;

endmodule

// File: rtl/seq_player.sv
// Sequence player: walks a taglist of {start,end,last} descriptors and
// emits a playback address stream, with up/down sequence selection.
// Optional feature macro: SEQ_AUTO_ADVANCE_EN adds input auto_adv, which
// advances to the next sequence at end-of-sequence instead of loop/hold.
// Ports:
//   clock_n     clock (rising edge)
//   reset       async active-high reset
//   seq_up/dn   one-cycle select pulses (both together are ignored)
//   loop_en     1 = replay sequence at end, 0 = stop in HOLD
//   auto_adv    (SEQ_AUTO_ADVANCE_EN only) chain into next sequence at end
//   tbl_data    taglist RAM read data, one cycle after tbl_addr
//   tbl_addr    taglist read address (mirrors seq_idx)
//   seq_idx     current sequence index
//   addr        playback address; addr_valid high in PLAY
//   at_end      PLAY cycle with addr at end; done high in HOLD
module seq_player
  import seq_player_pkg::*;
#(
  parameter  int unsigned ADDR_W = ADDR_W_DEF,
  parameter  int unsigned IDX_W  = IDX_W_DEF,
  localparam int unsigned DESC_W = desc_w(ADDR_W)
) (
  input  logic              clock_n,
  input  logic              reset,
  input  logic              seq_up,
  input  logic              seq_dn,
  input  logic              loop_en,
`ifdef SEQ_AUTO_ADVANCE_EN
  input  logic              auto_adv,
`endif
  input  logic [DESC_W-1:0] tbl_data,
  output logic [IDX_W-1:0]  tbl_addr,
  output logic [IDX_W-1:0]  seq_idx,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              at_end,
  output logic              done
);

  localparam int unsigned START_LSB = desc_start_lsb(ADDR_W);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  seq_idx_q, seq_idx_d;
  logic              last_q;
  logic              addr_valid_q, addr_valid_d;
  logic              done_q, done_d;
  logic              load_c, step_c, end_hit_c, auto_c;
  logic              btn_up_c, btn_dn_c;
  logic [IDX_W-1:0]  idx_up_c, idx_dn_c;

`ifdef SEQ_AUTO_ADVANCE_EN
  assign auto_c = auto_adv;
`else
  assign auto_c = 1'b0;
`endif

  // Simultaneous up+down cancel out.
  assign btn_up_c = seq_up & ~seq_dn;
  assign btn_dn_c = seq_dn & ~seq_up;
  assign idx_up_c = last_q ? '0 : seq_idx_q + IDX_W'(1);
  assign idx_dn_c = (seq_idx_q == '0) ? '0 : seq_idx_q - IDX_W'(1);

  // State register and registered outputs.
  always_ff @(posedge clock_n or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      seq_idx_q    <= '0;
      last_q       <= 1'b0;
      addr_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_idx_q    <= seq_idx_d;
      last_q       <= load_c ? tbl_data[DESC_LAST_BIT] : last_q;
      addr_valid_q <= addr_valid_d;
      done_q       <= done_d;
    end
  end

  // Next state and sequence index; buttons beat end-of-sequence handling.
  always_comb begin
    state_d   = state_q;
    seq_idx_d = seq_idx_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_PLAY;
      ST_PLAY: begin
        if (btn_up_c) begin
          seq_idx_d = idx_up_c;
          state_d   = ST_FETCH;
        end else if (btn_dn_c) begin
          seq_idx_d = idx_dn_c;
          state_d   = ST_FETCH;
        end else if (end_hit_c) begin
          if (auto_c) begin
            seq_idx_d = idx_up_c;
            state_d   = ST_FETCH;
          end else if (!loop_en) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (btn_up_c) begin
          seq_idx_d = idx_up_c;
          state_d   = ST_FETCH;
        end else if (btn_dn_c) begin
          seq_idx_d = idx_dn_c;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath controls and next values of the registered status outputs.
  always_comb begin
    load_c       = (state_q == ST_LOAD);
    step_c       = (state_q == ST_PLAY) && (state_d == ST_PLAY);
    addr_valid_d = (state_d == ST_PLAY);
    done_d       = (state_d == ST_HOLD);
  end

  seq_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .clk_i       (clock_n),
    .rst_i       (reset),
    .load_i      (load_c),
    .start_i     (tbl_data[START_LSB +: ADDR_W]),
    .end_i       (tbl_data[DESC_END_LSB +: ADDR_W]),
    .step_i      (step_c),
    .valid_d_i   (addr_valid_d),
    .addr_o      (addr),
    .at_end_o    (at_end),
    .end_hit_c_o (end_hit_c)
  );

  assign tbl_addr   = seq_idx_q;
  assign seq_idx    = seq_idx_q;
  assign addr_valid = addr_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player with a one-cycle-latency taglist RAM model.
module tb_seq_player;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned IDX_W  = 7;
  localparam int unsigned DESC_W = 2 * ADDR_W + 1;

  logic              clock_n = 1'b0;
  logic              reset;
  logic              seq_up, seq_dn, loop_en;
  logic              auto_adv;
  logic [DESC_W-1:0] tbl_data;
  logic [IDX_W-1:0]  tbl_addr, seq_idx;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid, at_end, done;

  logic [DESC_W-1:0] mem [0:127];
  int                s_tab [5] = '{'h000, 'h006, 'h00D, 'h016, 'h02B};
  int                e_tab [5] = '{'h005, 'h00C, 'h015, 'h02A, 'h03F};

  int total = 0;
  int bad   = 0;

  seq_player #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
    .clock_n    (clock_n),
    .reset      (reset),
    .seq_up     (seq_up),
    .seq_dn     (seq_dn),
    .loop_en    (loop_en),
`ifdef SEQ_AUTO_ADVANCE_EN
    .auto_adv   (auto_adv),
`endif
    .tbl_data   (tbl_data),
    .tbl_addr   (tbl_addr),
    .seq_idx    (seq_idx),
    .addr       (addr),
    .addr_valid (addr_valid),
    .at_end     (at_end),
    .done       (done)
  );

  always #5 clock_n = ~clock_n;

  always @(posedge clock_n) tbl_data <= mem[tbl_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock_n);
    @(negedge clock_n);
  endtask

  task automatic press(input logic up, input logic dn);
    seq_up = up;
    seq_dn = dn;
    tick();
    seq_up = 1'b0;
    seq_dn = 1'b0;
  endtask

  // Check n consecutive looping PLAY cycles of sequence idx starting at s.
  task automatic expect_play(input int idx, input int s, input int e, input int n);
    int exp;
    for (int i = 0; i < n; i++) begin
      exp = s + (i % (e - s + 1));
      chk("play_addr", 32'(addr), 32'(exp));
      chk("play_at_end", 32'(at_end), 32'(exp == e));
      chk("play_valid", 32'(addr_valid), 32'd1);
      chk("play_idx", 32'(seq_idx), 32'(idx));
      chk("tbl_addr", 32'(tbl_addr), 32'(idx));
      tick();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_idx"}, 32'(seq_idx), 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_valid"}, 32'(addr_valid), 32'd0);
    chk({tag, "_at_end"}, 32'(at_end), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    for (int i = 0; i < 5; i++)
      mem[i] = {ADDR_W'(s_tab[i]), ADDR_W'(e_tab[i]), (i == 4) ? 1'b1 : 1'b0};

    reset = 1'b1; seq_up = 1'b0; seq_dn = 1'b0; loop_en = 1'b1; auto_adv = 1'b0;
    repeat (2) @(negedge clock_n);
    chk_zero("rst");

    // Release: FETCH, LOAD, then first valid on the third edge.
    reset = 1'b0;
    tick(); chk("fetch_valid", 32'(addr_valid), 32'd0);
    tick(); chk("load_valid", 32'(addr_valid), 32'd0);
    tick();
    expect_play(0, 'h000, 'h005, 12);

    // Step up through every sequence, then wrap on the last one.
    for (int k = 1; k <= 4; k++) begin
      press(1'b1, 1'b0);
      chk("up_idx", 32'(seq_idx), 32'(k));
      chk("up_gap_valid", 32'(addr_valid), 32'd0);
      tick(); tick();
      expect_play(k, s_tab[k], e_tab[k], e_tab[k] - s_tab[k] + 3);
    end
    press(1'b1, 1'b0);
    chk("wrap_idx", 32'(seq_idx), 32'd0);
    tick(); tick();
    expect_play(0, 'h000, 'h005, 6);

    // Down at index 0 saturates.
    press(1'b0, 1'b1);
    chk("dn0_idx", 32'(seq_idx), 32'd0);
    tick(); tick();
    expect_play(0, 'h000, 'h005, 6);

    // Up to 3 then down to 2.
    for (int k = 1; k <= 3; k++) begin
      press(1'b1, 1'b0);
      tick(); tick();
    end
    chk("at3_idx", 32'(seq_idx), 32'd3);
    press(1'b0, 1'b1);
    chk("dn3_idx", 32'(seq_idx), 32'd2);
    tick(); tick();
    expect_play(2, 'h00D, 'h015, 9);

    // Both buttons together: ignored, playback continues.
    press(1'b1, 1'b1);
    chk("both_idx", 32'(seq_idx), 32'd2);
    chk("both_addr", 32'(addr), 32'h00E);
    chk("both_valid", 32'(addr_valid), 32'd1);
    tick(); tick();
    chk("pre_rst_addr", 32'(addr), 32'h010);

    // Asynchronous reset mid-cycle clears outputs at once.
    #2 reset = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clock_n);
    reset = 1'b0;
    tick(); tick(); tick();
    expect_play(0, 'h000, 'h005, 5);

    // Button on the end cycle with loop off: button wins over HOLD.
    chk("end_cycle_at_end", 32'(at_end), 32'd1);
    loop_en = 1'b0;
    press(1'b1, 1'b0);
    chk("prio_idx", 32'(seq_idx), 32'd1);
    chk("prio_done", 32'(done), 32'd0);
    tick(); tick();
    // One-shot play of index 1, then HOLD at its end address.
    for (int i = 0; i < 7; i++) begin
      chk("once_addr", 32'(addr), 32'('h006 + i));
      chk("once_at_end", 32'(at_end), 32'(i == 6));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 32'(addr_valid), 32'd0);
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_addr", 32'(addr), 32'h00C);
      chk("hold_at_end", 32'(at_end), 32'd0);
      tick();
    end
    loop_en = 1'b1;
    press(1'b1, 1'b0);
    chk("hold_up_idx", 32'(seq_idx), 32'd2);
    chk("hold_up_done", 32'(done), 32'd0);
    tick(); tick();
    expect_play(2, 'h00D, 'h015, 10);

    // Reversed descriptor (start > end) plays only its start address.
    mem[3] = {ADDR_W'('h020), ADDR_W'('h010), 1'b0};
    press(1'b1, 1'b0);
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk("rev_addr", 32'(addr), 32'h020);
      chk("rev_at_end", 32'(at_end), 32'd1);
      chk("rev_valid", 32'(addr_valid), 32'd1);
      tick();
    end
    loop_en = 1'b0;
    tick();
    chk("rev_hold_done", 32'(done), 32'd1);
    chk("rev_hold_addr", 32'(addr), 32'h020);

`ifdef SEQ_AUTO_ADVANCE_EN
    // Auto-advance chains all sequences, wrapping after the last.
    begin
      int exp_a;
      int cnt;
      mem[3] = {ADDR_W'(s_tab[3]), ADDR_W'(e_tab[3]), 1'b0};
      reset = 1'b1; auto_adv = 1'b1;
      tick();
      reset = 1'b0;
      exp_a = 0;
      cnt   = 0;
      for (int c = 0; c < 400 && cnt < 70; c++) begin
        if (addr_valid) begin
          chk("auto_addr", 32'(addr), 32'(exp_a));
          exp_a = (exp_a == 'h03F) ? 0 : exp_a + 1;
          cnt++;
        end
        tick();
      end
      chk("auto_count", 32'(cnt), 32'd70);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
